// File: rtl/pooling_2d_stream.sv
// pooling_2d_stream: 2x2 stride-2 max/average pooling over a raster pixel stream.
// One row of horizontal pair results is kept on chip, so every input pixel is
// consumed exactly once and each pooled result leaves with its BRAM address.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start, in_ready low
// S_RUN  | accepting pixels, in_ready high until the last pixel lands
// S_DONE | one cycle after the last pixel, then back to idle with done
module pooling_2d_stream #(
    parameter int DATA_W = 12,
    parameter int IN_W   = 28,
    parameter int IN_H   = 28,
    parameter int SIGNED = 0,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    localparam int OUT_W = IN_W / 2;
    localparam int N_OUT = OUT_W * (IN_H / 2);
    localparam int CW    = $clog2(IN_W);
    localparam int RW    = $clog2(IN_H);
    localparam int OW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    if ((IN_W % 2) != 0 || IN_W < 2) begin : g_bad_in_w
        $error("pooling_2d_stream: IN_W must be even and >= 2");
    end
    if ((IN_H % 2) != 0 || IN_H < 2) begin : g_bad_in_h
        $error("pooling_2d_stream: IN_H must be even and >= 2");
    end
    if ((64'd1 << ADDR_W) < 64'(N_OUT)) begin : g_bad_addr_w
        $error("pooling_2d_stream: ADDR_W too narrow for the output map");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state;
    logic              mode_q;
    logic [CW-1:0]     c;
    logic [RW-1:0]     r;
    logic [DATA_W-1:0] h_reg;
    logic [ADDR_W-1:0] addr_cnt;
    logic [DATA_W:0]   row_buf [OUT_W];

    // Widen by one bit; the extension bit is the sign only for signed pixels,
    // which makes a signed compare correct for both pixel flavours.
    function automatic logic [DATA_W:0] ext1(input logic [DATA_W-1:0] x);
        return {x[DATA_W-1] & (SIGNED != 0), x};
    endfunction

    // Second widening for the vertical sum; an unsigned pair sum uses its top bit
    // as magnitude, so it must be zero-extended.
    function automatic logic [DATA_W+1:0] ext2(input logic [DATA_W:0] x);
        return {x[DATA_W] & (SIGNED != 0), x};
    endfunction

    logic              accept;
    logic              last_c;
    logic              last_r;
    logic [OW-1:0]     col;
    logic [DATA_W:0]   pix_x;
    logic [DATA_W:0]   hr_x;
    logic [DATA_W:0]   h_max;
    logic [DATA_W:0]   h_val;
    logic [DATA_W:0]   rb;
    logic [DATA_W:0]   v_max;
    logic [DATA_W+1:0] v_sum;
    logic [DATA_W-1:0] result;

    assign accept = in_valid && in_ready;
    assign last_c = (c == CW'(IN_W - 1));
    assign last_r = (r == RW'(IN_H - 1));
    assign col    = OW'(c >> 1);
    assign pix_x  = ext1(in_data);
    assign hr_x   = ext1(h_reg);
    assign h_max  = ($signed(pix_x) > $signed(hr_x)) ? pix_x : hr_x;
    assign h_val  = mode_q ? (hr_x + pix_x) : h_max;
    assign rb     = row_buf[col];
    assign v_max  = ($signed(h_val) > $signed(rb)) ? h_val : rb;
    assign v_sum  = ext2(rb) + ext2(h_val);
    // Dropping the two low bits is a floor divide by 4 for either signedness.
    assign result = mode_q ? v_sum[DATA_W+1:2] : v_max[DATA_W-1:0];

    // Park the horizontal pair result of each even row until its partner row arrives.
    always_ff @(posedge clk) begin
        if (accept && c[0] && !r[0]) begin
            row_buf[col] <= h_val;
        end
    end

    // Run sequencing, raster counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mode_q    <= 1'b0;
            c         <= '0;
            r         <= '0;
            h_reg     <= '0;
            addr_cnt  <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        mode_q   <= mode;
                        c        <= '0;
                        r        <= '0;
                        addr_cnt <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (!c[0]) begin
                            h_reg <= in_data;
                        end else if (r[0]) begin
                            out_valid <= 1'b1;
                            out_data  <= result;
                            out_addr  <= addr_cnt;
                            addr_cnt  <= addr_cnt + 1'b1;
                        end
                        if (last_c) begin
                            c <= '0;
                            if (last_r) begin
                                state    <= S_DONE;
                                in_ready <= 1'b0;
                            end else begin
                                r <= r + 1'b1;
                            end
                        end else begin
                            c <= c + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pooling_2d_stream.sv
// tb_pooling_2d_stream: three pooling instances (default 28x28 unsigned, 4x4
// unsigned, 4x4 signed 8-bit) driven one at a time from a shared pixel bus and
// checked against a window-by-window max/floor-average model.
module tb_pooling_2d_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic        in_valid;
    logic [11:0] in_data;
    logic        start_a, start_b, start_c;

    logic        rdy_a, ov_a, busy_a, done_a;
    logic [11:0] od_a;
    logic [7:0]  oa_a;
    logic        rdy_b, ov_b, busy_b, done_b;
    logic [11:0] od_b;
    logic [1:0]  oa_b;
    logic        rdy_c, ov_c, busy_c, done_c;
    logic [7:0]  od_c;
    logic [1:0]  oa_c;

    always #5 clk = ~clk;

    pooling_2d_stream u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_a),
        .out_valid(ov_a), .out_data(od_a), .out_addr(oa_a),
        .busy(busy_a), .done(done_a)
    );

    pooling_2d_stream #(.DATA_W(12), .IN_W(4), .IN_H(4), .SIGNED(0), .ADDR_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_b),
        .out_valid(ov_b), .out_data(od_b), .out_addr(oa_b),
        .busy(busy_b), .done(done_b)
    );

    pooling_2d_stream #(.DATA_W(8), .IN_W(4), .IN_H(4), .SIGNED(1), .ADDR_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .mode(mode),
        .in_valid(in_valid), .in_data(in_data[7:0]), .in_ready(rdy_c),
        .out_valid(ov_c), .out_data(od_c), .out_addr(oa_c),
        .busy(busy_c), .done(done_c)
    );

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int pix [784];
    int expq [$];

    int qa_addr [$], qa_data [$], qb_addr [$], qb_data [$], qc_addr [$], qc_data [$];
    int n_done_a = 0, n_done_b = 0, n_done_c = 0;
    int last_ov_a = 0, last_ov_b = 0, last_ov_c = 0;
    int done_cyc_a = 0, done_cyc_b = 0, done_cyc_c = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output capture, sampled on the falling edge.
    always @(negedge clk) begin
        if (ov_a) begin qa_addr.push_back(int'(oa_a)); qa_data.push_back(int'(od_a)); last_ov_a = cyc; end
        if (done_a) begin n_done_a++; done_cyc_a = cyc; end
        if (ov_b) begin qb_addr.push_back(int'(oa_b)); qb_data.push_back(int'(od_b)); last_ov_b = cyc; end
        if (done_b) begin n_done_b++; done_cyc_b = cyc; end
        if (ov_c) begin qc_addr.push_back(int'(oa_c)); qc_data.push_back(int'(od_c)); last_ov_c = cyc; end
        if (done_c) begin n_done_c++; done_cyc_c = cyc; end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish within 2 ms");
        $fatal(1, "watchdog expired");
    end

    function automatic logic rdy(input int sel);
        case (sel) 0: return rdy_a; 1: return rdy_b; default: return rdy_c; endcase
    endfunction
    function automatic logic busyf(input int sel);
        case (sel) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
    endfunction
    function automatic int qsize(input int sel);
        case (sel) 0: return qa_addr.size(); 1: return qb_addr.size(); default: return qc_addr.size(); endcase
    endfunction
    function automatic int qaddr(input int sel, input int k);
        case (sel) 0: return qa_addr[k]; 1: return qb_addr[k]; default: return qc_addr[k]; endcase
    endfunction
    function automatic int qdata(input int sel, input int k);
        case (sel) 0: return qa_data[k]; 1: return qb_data[k]; default: return qc_data[k]; endcase
    endfunction
    function automatic int ndone(input int sel);
        case (sel) 0: return n_done_a; 1: return n_done_b; default: return n_done_c; endcase
    endfunction
    function automatic int done_gap(input int sel);
        case (sel)
            0: return done_cyc_a - last_ov_a;
            1: return done_cyc_b - last_ov_b;
            default: return done_cyc_c - last_ov_c;
        endcase
    endfunction
    function automatic int mask(input int sel);
        return (sel == 2) ? 32'hFF : 32'hFFF;
    endfunction

    task automatic set_start(input int sel, input logic v);
        start_a = (sel == 0) ? v : 1'b0;
        start_b = (sel == 1) ? v : 1'b0;
        start_c = (sel == 2) ? v : 1'b0;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected pooled map: per 2x2 window, the largest pixel or floor(sum/4).
    task automatic model(input int w, input int h, input bit m);
        int a, b, cc, d, mx;
        expq.delete();
        for (int orow = 0; orow < h / 2; orow++) begin
            for (int ocol = 0; ocol < w / 2; ocol++) begin
                a  = pix[(2 * orow) * w + 2 * ocol];
                b  = pix[(2 * orow) * w + 2 * ocol + 1];
                cc = pix[(2 * orow + 1) * w + 2 * ocol];
                d  = pix[(2 * orow + 1) * w + 2 * ocol + 1];
                if (m) begin
                    expq.push_back((a + b + cc + d) >>> 2);
                end else begin
                    mx = a;
                    if (b > mx) mx = b;
                    if (cc > mx) mx = cc;
                    if (d > mx) mx = d;
                    expq.push_back(mx);
                end
            end
        end
    endtask

    task automatic run(input int sel, input int w, input int h, input bit m,
                       input bit gaps, input int abort_at, input bit poke);
        int base, d0, bad_rdy, n, t, n_chk;
        base    = qsize(sel);
        d0      = ndone(sel);
        bad_rdy = 0;
        n       = (abort_at > 0) ? abort_at : w * h;
        mode    = m;
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        mode = ~m;
        for (int i = 0; i < n; i++) begin
            while (gaps && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                if (rdy(sel) !== 1'b1) bad_rdy++;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = 12'(pix[i]);
            if (rdy(sel) !== 1'b1) bad_rdy++;
            if (poke && i == w + 3) set_start(sel, 1'b1);
            @(negedge clk);
            set_start(sel, 1'b0);
        end
        in_valid = 1'b0;
        check("in_ready_held", bad_rdy, 0);
        if (abort_at > 0) return;
        if (poke) set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        t = 0;
        while (ndone(sel) == d0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("done_pulses", ndone(sel) - d0, 1);
        check("done_after_last_out", done_gap(sel), 1);
        check("idle_after_run", {busyf(sel), rdy(sel)}, 0);
        model(w, h, m);
        check("out_count", qsize(sel) - base, expq.size());
        n_chk = expq.size();
        if (qsize(sel) - base < n_chk) n_chk = qsize(sel) - base;
        for (int k = 0; k < n_chk; k++) begin
            check("out_addr", qaddr(sel, base + k), k);
            check("out_data", qdata(sel, base + k), expq[k] & mask(sel));
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        mode     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        set_start(0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_a", {rdy_a, ov_a, busy_a, done_a, od_a, oa_a}, 0);
        check("rst_b", {rdy_b, ov_b, busy_b, done_b, od_b, oa_b}, 0);
        check("rst_c", {rdy_c, ov_c, busy_c, done_c, od_c, oa_c}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ramp r*28+c in max mode, start poked during RUN and DONE.
        for (int i = 0; i < 784; i++) pix[i] = i;
        run(0, 28, 28, 1'b0, 1'b0, 0, 1'b1);
        check("ramp_first", qa_data[qa_data.size() - 196], 29);
        check("ramp_last", qa_data[qa_data.size() - 1], 783);

        // Same ramp with random in_valid gaps.
        run(0, 28, 28, 1'b0, 1'b1, 0, 1'b0);

        // Random pixels, average mode, with gaps.
        for (int i = 0; i < 784; i++) pix[i] = int'($urandom_range(0, 4095));
        run(0, 28, 28, 1'b1, 1'b1, 0, 1'b0);

        // Abort after 300 pixels, then a clean ramp run.
        for (int i = 0; i < 784; i++) pix[i] = i;
        begin
            int d_before;
            d_before = n_done_a;
            run(0, 28, 28, 1'b0, 1'b0, 300, 1'b0);
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            check("abort_rst_a", {rdy_a, ov_a, busy_a, done_a, od_a, oa_a}, 0);
            rst_n = 1'b1;
            repeat (4) @(negedge clk);
            check("abort_no_done", n_done_a - d_before, 0);
        end
        run(0, 28, 28, 1'b0, 1'b1, 0, 1'b0);

        // 4x4: rows alternating 4/8 averaged, saturated pixels, random both modes.
        for (int i = 0; i < 16; i++) pix[i] = ((i / 4) % 2 == 0) ? 4 : 8;
        run(1, 4, 4, 1'b1, 1'b0, 0, 1'b0);
        check("avg_rows_val", qb_data[qb_data.size() - 1], 6);
        for (int i = 0; i < 16; i++) pix[i] = 4095;
        run(1, 4, 4, 1'b1, 1'b1, 0, 1'b0);
        for (int i = 0; i < 16; i++) pix[i] = int'($urandom_range(0, 4095));
        run(1, 4, 4, 1'b0, 1'b1, 0, 1'b1);
        run(1, 4, 4, 1'b1, 1'b0, 0, 1'b0);

        // Signed 8-bit: window {-128,-1,-2,-3} in the top-left corner.
        for (int i = 0; i < 16; i++) pix[i] = int'($urandom_range(0, 255)) - 128;
        pix[0] = -128; pix[1] = -1; pix[4] = -2; pix[5] = -3;
        run(2, 4, 4, 1'b0, 1'b0, 0, 1'b0);
        check("signed_max", qc_data[qc_data.size() - 4], 8'hFF);
        run(2, 4, 4, 1'b1, 1'b1, 0, 1'b0);
        check("signed_avg", qc_data[qc_data.size() - 4], 8'hDE);
        for (int i = 0; i < 16; i++) pix[i] = int'($urandom_range(0, 255)) - 128;
        run(2, 4, 4, 1'b1, 1'b1, 0, 1'b0);
        run(2, 4, 4, 1'b0, 1'b1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pooling_2d_stream.md
Name: pooling_2d_stream

Overview:
- Parametrised successor to the 28x28 BRAM max-pool block.
- Accepts one feature-map channel as a raster-order pixel stream (row-major, column fastest) and performs 2x2, stride-2 pooling on it.
- Pooling is max or average, selected per run.
- Pooled results are emitted as a stream with the write address for the next-layer BRAM. A one-row internal buffer removes the read-modify-write BRAM traffic of the previous generation.

Parameters:
- DATA_W, 12, pixel width in bits.
- IN_W, 28, input map width in pixels. Must be even and >=2; elaboration error otherwise.
- IN_H, 28, input map height in pixels. Must be even and >=2; elaboration error otherwise.
- SIGNED, 0, 1 = pixels are two's complement (signed compare, arithmetic shift); 0 = unsigned.
- ADDR_W, 8, output address width. Must satisfy 2^ADDR_W >= (IN_W/2)*(IN_H/2).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a run when idle
- mode  in  1  0 = max pool, 1 = average pool; sampled on accepted start
- in_valid  in  1  input pixel valid
- in_data  in  DATA_W  input pixel
- in_ready  out  1  block accepts a pixel this cycle
- out_valid  out  1  pooled result valid (single-cycle strobe)
- out_data  out  DATA_W  pooled result
- out_addr  out  ADDR_W  linear output address = orow*(IN_W/2) + ocol
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, FSM to IDLE, counters and holding registers cleared.
- Reset mid-run aborts the run with no done pulse. Row-buffer contents need not be cleared.
- FSM states:
  - IDLE: busy=0, in_ready=0.
  - IDLE->RUN on start=1: latch mode, clear r/c counters.
  - RUN: busy=1, in_ready=1. A pixel is accepted when in_valid && in_ready. Counters c (0..IN_W-1) and r (0..IN_H-1) advance only on accepted pixels. When c wraps, r increments.
  - RUN->DONE the cycle after the last pixel (r=IN_H-1, c=IN_W-1) is accepted; in_ready drops that same cycle.
  - DONE: busy=1, in_ready=0. done=1 for exactly one cycle, then -> IDLE.
  - start while not IDLE is ignored.
- Horizontal stage:
  - On accepted pixel with c even: h_reg <= pixel.
  - On c odd: h = max(h_reg, pixel) in max mode, or h_reg + pixel at DATA_W+1 bits (sign-extended if SIGNED) in average mode.
- Vertical stage:
  - r even, c odd: row_buf[c>>1] <= h. Depth IN_W/2, width DATA_W+1.
  - r odd, c odd: result = max(row_buf[c>>1], h), or the sum of both at DATA_W+2 bits >> 2. The shift truncates toward -inf (arithmetic when SIGNED).
- Output:
  - out_valid=1 on the clock edge after the accepting edge of pixel (r odd, c odd), i.e. latency 1.
  - out_data = result; out_addr = (r>>1)*(IN_W/2) + (c>>1).
  - out_data and out_addr hold their values until the next strobe.
- Comparisons: ties select either operand (same value). Max uses signed compare iff SIGNED=1.
- Average arithmetic never overflows internally; the result always fits DATA_W.
- Gaps: in_valid low stalls all counters and the pipeline with no state change.
- Final output: the last out_valid coincides with the entry into DONE. done pulses the cycle after the last out_valid.
- Totals: (IN_W/2)*(IN_H/2) out_valid strobes per run, addresses 0..N-1, strictly increasing.

Test Plan:
- Default params, max mode, 784 pixels in_data = r*28+c, in_valid held 1 -> 196 outputs; addr k holds value (2*(k/14)+1)*28 + 2*(k%14)+1. Output 0 = 29, output 195 = 783. done exactly 1 cycle after the last strobe.
- Average mode, rows alternating all-4 / all-8 (IN_W=IN_H=4) -> 4 outputs each 6, addresses 0..3.
- SIGNED=1, DATA_W=8, window {-128,-1,-2,-3}: max -> -1 (0xFF); avg -> -134>>2 = -34 (0xDE).
- Random in_valid gaps (50% duty) on the first scenario -> identical output sequence. in_ready stays 1 through gaps until the last pixel.
- rst_n asserted mid-run (after 300 pixels), then a new start -> no done for the aborted run; the new run yields a full 196 correct outputs starting at addr 0.
- start pulsed during RUN and DONE -> ignored, no restart. Window all max-value 0xFFF in avg mode -> 0xFFF (no overflow).
